// File: rtl/sort_pkg.sv
// Shared types and constants for the insertion-sort controller.
// Holds the FSM state encoding, default sizes and the counter-width helper.
package sort_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_N  = 4;

  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Bits needed to count from 0 up to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_cell.sv
// One compare-and-hold stage of the sort chain: keeps the larger of held/candidate
// on insert, forwards the smaller one, shifts toward the head on drain.
module sort_cell #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_insert,
  input  logic          i_shift,
  input  logic [DW-1:0] i_cand,
  input  logic [DW-1:0] i_next,
  output logic [DW-1:0] o_held,
  output logic [DW-1:0] o_pass
);

  logic [DW-1:0] r_held;
  logic          w_take;

  // Strict compare so equal words travel further down and keep arrival order.
  always_comb begin
    w_take = (i_cand > r_held);
    if (w_take) begin
      o_pass = r_held;
    end else begin
      o_pass = i_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= {DW{1'b0}};
    end else if (i_clear) begin
      r_held <= {DW{1'b0}};
    end else if (i_insert) begin
      r_held <= w_take ? i_cand : r_held;
    end else if (i_shift) begin
      r_held <= i_next;
    end else begin
      r_held <= r_held;
    end
  end

  assign o_held = r_held;

endmodule

// File: rtl/sort_controller.sv
// Streaming insertion sorter: loads up to N words into a compare chain, then
// drains them largest first; flush aborts a batch, rst overrides everything.
module sort_controller
  import sort_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int N  = DEF_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  input  logic          flush,
  output logic          busy
);

  localparam int CW = cnt_width(N);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] w_acc_nxt;
  logic [CW-1:0] r_drn;
  logic [CW-1:0] w_drn_nxt;
  logic [CW-1:0] w_acc_inc;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_insert;
  logic          w_xfer;
  logic          w_final;
  logic          w_clear;

  logic [DW-1:0] w_cand [N+1];
  logic [DW-1:0] w_held [N];

  assign w_cand[0] = in_data;

  // Candidate ripples head-to-tail on insert; held words move one cell toward the head on drain.
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    logic [DW-1:0] w_next;
    if (gi == N - 1) begin : g_tail
      assign w_next = {DW{1'b0}};
    end else begin : g_body
      assign w_next = w_held[gi+1];
    end
    sort_cell #(.DW(DW)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_clear),
      .i_insert (w_insert),
      .i_shift  (w_xfer),
      .i_cand   (w_cand[gi]),
      .i_next   (w_next),
      .o_held   (w_held[gi]),
      .o_pass   (w_cand[gi+1])
    );
  end

  // Handshake qualifiers; flush and rst mask both sides so no transfer counts.
  always_comb begin
    w_in_ready  = !rst && !flush && (r_state == ST_LOAD);
    w_out_valid = !rst && !flush && (r_state == ST_DRAIN);
    w_insert    = in_valid && w_in_ready;
    w_xfer      = w_out_valid && out_ready;
    w_acc_inc   = r_acc + CW'(1);
    w_final     = w_insert && ((w_acc_inc == CW'(N)) || in_last);
  end

  // Next-state and counter logic; the drain length is the accepted count, not the non-zero cells.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_drn_nxt   = r_drn;
    w_clear     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_LOAD;
      w_acc_nxt   = {CW{1'b0}};
      w_drn_nxt   = {CW{1'b0}};
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_final) begin
            w_state_nxt = ST_DRAIN;
            w_acc_nxt   = {CW{1'b0}};
            w_drn_nxt   = w_acc_inc;
          end else if (w_insert) begin
            w_acc_nxt = w_acc_inc;
          end else begin
            w_acc_nxt = r_acc;
          end
        end
        ST_DRAIN: begin
          if (w_xfer && (r_drn == CW'(1))) begin
            w_state_nxt = ST_LOAD;
            w_drn_nxt   = {CW{1'b0}};
            w_clear     = 1'b1;
          end else if (w_xfer) begin
            w_drn_nxt = r_drn - CW'(1);
          end else begin
            w_drn_nxt = r_drn;
          end
        end
        default: begin
          w_state_nxt = ST_LOAD;
          w_acc_nxt   = {CW{1'b0}};
          w_drn_nxt   = {CW{1'b0}};
          w_clear     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_acc   <= {CW{1'b0}};
      r_drn   <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_drn   <= w_drn_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_held[0];
  assign out_last  = w_out_valid && (r_drn == CW'(1));
  assign busy      = !rst && !((r_state == ST_LOAD) && (r_acc == {CW{1'b0}}));

endmodule

// File: tb/tb_sort_controller.sv
// Directed bench for sort_controller (DW=8, N=4) with hand-computed expectations.
module tb_sort_controller;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       flush;
  logic       busy;

  int total;
  int bad;

  sort_controller #(.DW(8), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .flush     (flush),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop(input logic [7:0] d, input logic l);
    out_ready = 1'b1;
    #1;
    chk("pop_valid", {31'd0, out_valid}, 32'd1);
    chk("pop_data", {24'd0, out_data}, {24'd0, d});
    chk("pop_last", {31'd0, out_last}, {31'd0, l});
    chk("pop_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic stall(input logic [7:0] d, input logic l);
    out_ready = 1'b0;
    #1;
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_data", {24'd0, out_data}, {24'd0, d});
    chk("stall_last", {31'd0, out_last}, {31'd0, l});
    tick();
  endtask

  task automatic idle_load(input string tag);
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle_load("post_rst");

    // 3,9,1,7 -> 9,7,3,1
    push(8'd3, 1'b0);
    #1;
    chk("busy_after_one", {31'd0, busy}, 32'd1);
    push(8'd9, 1'b0);
    push(8'd1, 1'b0);
    push(8'd7, 1'b0);
    #1;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    pop(8'd9, 1'b0);
    pop(8'd7, 1'b0);
    pop(8'd3, 1'b0);
    pop(8'd1, 1'b1);
    idle_load("after_b1");

    // Ties and zeros
    push(8'd5, 1'b0);
    push(8'd5, 1'b0);
    push(8'd2, 1'b0);
    push(8'd5, 1'b0);
    pop(8'd5, 1'b0);
    pop(8'd5, 1'b0);
    pop(8'd5, 1'b0);
    pop(8'd2, 1'b1);
    push(8'd0, 1'b0);
    push(8'd0, 1'b0);
    push(8'd8, 1'b0);
    push(8'd0, 1'b0);
    pop(8'd8, 1'b0);
    pop(8'd0, 1'b0);
    pop(8'd0, 1'b0);
    pop(8'd0, 1'b1);
    idle_load("after_zero");

    // Short batch via in_last
    push(8'd4, 1'b0);
    push(8'd200, 1'b1);
    pop(8'd200, 1'b0);
    pop(8'd4, 1'b1);
    idle_load("after_short");

    // One-word batches, including a zero word
    push(8'd77, 1'b1);
    pop(8'd77, 1'b1);
    push(8'd0, 1'b1);
    pop(8'd0, 1'b1);
    idle_load("after_single");

    // Backpressure: out_ready pattern 1,0,0,1,0,0,...
    push(8'd10, 1'b0);
    push(8'd20, 1'b0);
    push(8'd30, 1'b0);
    push(8'd40, 1'b0);
    pop(8'd40, 1'b0);
    stall(8'd30, 1'b0);
    stall(8'd30, 1'b0);
    pop(8'd30, 1'b0);
    stall(8'd20, 1'b0);
    stall(8'd20, 1'b0);
    pop(8'd20, 1'b0);
    stall(8'd10, 1'b1);
    stall(8'd10, 1'b1);
    pop(8'd10, 1'b1);
    idle_load("after_stall");

    // Flush mid-drain with 6,2 still held, handshake offered in the same cycle
    push(8'd9, 1'b0);
    push(8'd6, 1'b0);
    push(8'd2, 1'b0);
    push(8'd8, 1'b0);
    pop(8'd9, 1'b0);
    pop(8'd8, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd99;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    idle_load("after_flush");
    push(8'd1, 1'b0);
    push(8'd2, 1'b0);
    push(8'd3, 1'b0);
    push(8'd4, 1'b0);
    pop(8'd4, 1'b0);
    pop(8'd3, 1'b0);
    pop(8'd2, 1'b0);
    pop(8'd1, 1'b1);

    // Flush mid-load drops accepted words
    push(8'd33, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_load("after_load_flush");

    // Reset mid-load
    push(8'd50, 1'b0);
    push(8'd60, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd120;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_last", {31'd0, out_last}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle_load("after_midrst");
    push(8'd7, 1'b0);
    push(8'd3, 1'b0);
    push(8'd11, 1'b0);
    push(8'd5, 1'b0);
    pop(8'd11, 1'b0);
    pop(8'd7, 1'b0);
    pop(8'd5, 1'b0);
    pop(8'd3, 1'b1);

    // Reset mid-drain
    push(8'd90, 1'b0);
    push(8'd80, 1'b1);
    pop(8'd90, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_load("after_drain_rst");
    push(8'd15, 1'b1);
    pop(8'd15, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
